// File: rtl/alu_pkg.sv
// Shared encodings for the iterative ARM ALU: opcodes, FSM states, flag layout.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_SBC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // nzcv bit positions: {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] MASK_ALL  = 4'b1111;
  localparam logic [3:0] MASK_NZ   = 4'b1100;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  function automatic logic [3:0] merge_flags(input logic [3:0] old_f,
                                             input logic [3:0] new_f,
                                             input logic [3:0] mask);
    return (old_f & ~mask) | (new_f & mask);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Shift-add multiplier keeping only the low WIDTH bits; one iteration per clock.
// done_o is asserted during the last iteration and product_o carries that iteration's sum.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q & (cnt_q == LAST);
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done_o) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU with valid/ready handshakes and a registered NZCV flag register.
// Non-MUL ops finish in one clock; MUL runs WIDTH clocks in mul_iter.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       op,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic             sf_q, sf_d;

  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             alu_v;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_mask;
  logic [3:0]       alu_flags;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign is_mul    = MUL_EN && (op == OP_MUL);
  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign nzcv      = nzcv_q;

  // Carry-in reads the flag register directly: the previous op's flags land
  // on the same edge that makes in_ready visible for the next op.
  always_comb begin
    b_op = src_b;
    cin  = 1'b0;
    case (op)
      OP_SUB: begin b_op = ~src_b; cin = 1'b1;           end
      OP_ADC: begin                cin = nzcv_q[FLAG_C]; end
      OP_SBC: begin b_op = ~src_b; cin = nzcv_q[FLAG_C]; end
      default: ;
    endcase
  end

  assign sum   = {1'b0, src_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
  assign alu_v = (src_a[WIDTH-1] == b_op[WIDTH-1]) & (sum[WIDTH-1] != src_a[WIDTH-1]);

  always_comb begin
    alu_res  = sum[WIDTH-1:0];
    alu_mask = MASK_ALL;
    case (op)
      OP_AND: begin alu_res = src_a & src_b; alu_mask = MASK_NZ;   end
      OP_ORR: begin alu_res = src_a | src_b; alu_mask = MASK_NZ;   end
      OP_EOR: begin alu_res = src_a ^ src_b; alu_mask = MASK_NZ;   end
      OP_MUL: begin alu_res = '0;            alu_mask = MASK_NONE; end
      default: ;
    endcase
  end

  assign alu_flags = {alu_res[WIDTH-1], alu_res == '0, sum[WIDTH], alu_v};

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (accept & is_mul),
    .a_i       (src_a),
    .b_i       (src_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    nzcv_d   = nzcv_q;
    sf_d     = sf_q;
    case (state_q)
      ST_BUSY: begin
        if (mul_done) begin
          state_d  = ST_HOLD;
          result_d = mul_prod;
          if (sf_q) begin
            nzcv_d = merge_flags(nzcv_q, {mul_prod[WIDTH-1], mul_prod == '0, 2'b00}, MASK_NZ);
          end
        end
      end
      default: begin
        if (accept) begin
          if (is_mul) begin
            state_d = ST_BUSY;
            sf_d    = set_flags;
          end else begin
            state_d  = ST_HOLD;
            result_d = alu_res;
            if (set_flags) begin
              nzcv_d = merge_flags(nzcv_q, alu_flags, alu_mask);
            end
          end
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      nzcv_q   <= 4'b0000;
      sf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      nzcv_q   <= nzcv_d;
      sf_q     <= sf_d;
    end
  end

endmodule
